// File: rtl/udma_cfg_bridge_pkg.sv
// Shared types and PADDR field positions
// for the uDMA cfg-bus APB bridge.
package udma_cfg_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam int REG_LSB = 2;
  localparam int REG_W   = 5;
  localparam int PER_LSB = 7;

endpackage

// File: rtl/udma_cfg_apb_bridge.sv
// APB slave that forwards accesses onto the
// one-hot uDMA peripheral cfg bus.
module udma_cfg_apb_bridge
  import udma_cfg_bridge_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_PERIPHS      = 4,
  parameter int PER_ID_WIDTH   = 2,
  parameter int TIMEOUT        = 255
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
  input  logic [31:0]                   PWDATA,
  input  logic                          PWRITE,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  output logic [31:0]                   PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [31:0]                   cfg_data_o,
  output logic [REG_W-1:0]              cfg_addr_o,
  output logic                          cfg_rwn_o,
  output logic [N_PERIPHS-1:0]          cfg_valid_o,
  input  logic [N_PERIPHS-1:0][31:0]    cfg_data_i,
  input  logic [N_PERIPHS-1:0]          cfg_ready_i
);

  state_e state_q, state_d;

  logic [PER_ID_WIDTH-1:0] per_id;
  logic [PER_ID_WIDTH-1:0] idx_q;
  logic [N_PERIPHS-1:0]    sel;
  logic [31:0]             rdata_sel;
  logic [31:0]             prdata_q;
  logic                    setup;
  logic                    acc;
  logic                    per_ok;
  logic                    rdy_sel;
  logic                    timeout_hit;
  logic                    unused_addr;

  assign setup  = PSEL & ~PENABLE;
  assign acc    = PSEL & PENABLE;
  assign per_id = PADDR[PER_LSB +: PER_ID_WIDTH];
  assign per_ok = 32'(per_id) < 32'(N_PERIPHS);

  // One-hot decode avoids indexing with a field
  // wider than the peripheral count needs.
  assign sel     = N_PERIPHS'(1) << idx_q;
  assign rdy_sel = |(cfg_ready_i & sel);

  assign unused_addr = ^PADDR;

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < N_PERIPHS; i++) begin
      if (sel[i]) rdata_sel = cfg_data_i[i];
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_to
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          cnt_q <= '0;
        end else if (state_q != REQ) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    end else begin : g_no_to
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (setup) state_d = per_ok ? REQ : ERR;
      end
      REQ: begin
        if (rdy_sel)          state_d = DONE;
        else if (timeout_hit) state_d = ERR;
      end
      DONE, ERR: begin
        // A dropped PSEL also ends the transfer.
        if (acc || !PSEL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cfg_addr_o <= '0;
      cfg_data_o <= '0;
      cfg_rwn_o  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && setup) begin
        idx_q      <= per_id;
        cfg_addr_o <= PADDR[REG_LSB +: REG_W];
        cfg_data_o <= PWDATA;
        cfg_rwn_o  <= ~PWRITE;
      end
      if (state_q == REQ && rdy_sel) begin
        prdata_q <= cfg_rwn_o ? rdata_sel : '0;
      end
    end
  end

  assign cfg_valid_o = (state_q == REQ) ? sel : '0;
  assign PREADY  = (state_q == DONE || state_q == ERR) & acc;
  assign PSLVERR = (state_q == ERR) & acc;
  assign PRDATA  = (state_q == DONE) ? prdata_q : '0;

endmodule

// File: tb/tb_udma_cfg_apb_bridge.sv
// Directed bench for the uDMA cfg APB bridge
// with hand-computed expected values.
module tb_udma_cfg_apb_bridge;

  logic              clk_i;
  logic              rstn_i;
  logic [11:0]       PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [31:0]       cfg_data_o;
  logic [4:0]        cfg_addr_o;
  logic              cfg_rwn_o;
  logic [3:0]        cfg_valid_o;
  logic [3:0][31:0]  cfg_data_i;
  logic [3:0]        cfg_ready_i;

  int checks;
  int failures;

  udma_cfg_apb_bridge #(
    .APB_ADDR_WIDTH(12),
    .N_PERIPHS(4),
    .PER_ID_WIDTH(3),
    .TIMEOUT(4)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PWRITE(PWRITE),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR),
    .cfg_data_o(cfg_data_o),
    .cfg_addr_o(cfg_addr_o),
    .cfg_rwn_o(cfg_rwn_o),
    .cfg_valid_o(cfg_valid_o),
    .cfg_data_i(cfg_data_i),
    .cfg_ready_i(cfg_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nx;
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp;
    @(negedge clk_i);
  endtask

  task automatic setup(input logic [11:0] a,
                       input logic [31:0] d,
                       input logic w);
    nx;
    PADDR   = a;
    PWDATA  = d;
    PWRITE  = w;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
  endtask

  task automatic idle;
    nx;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    cfg_ready_i = '0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rstn_i      = 1'b0;
    PADDR       = '0;
    PWDATA      = '0;
    PWRITE      = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    cfg_data_i  = '0;
    cfg_ready_i = '0;
    repeat (2) @(posedge clk_i);
    smp;
    chk("rst_valid", 32'(cfg_valid_o), 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_addr", 32'(cfg_addr_o), 32'h0);
    chk("rst_data", cfg_data_o, 32'h0);
    chk("rst_rwn", 32'(cfg_rwn_o), 32'h0);
    nx;
    rstn_i = 1'b1;

    // write per 1 reg 3, ready at once
    setup(12'h08C, 32'hA5, 1'b1);
    cfg_ready_i = 4'b0010;
    smp;
    chk("w_t0_valid", 32'(cfg_valid_o), 32'h0);
    nx; PENABLE = 1'b1; smp;
    chk("w_t1_valid", 32'(cfg_valid_o), 32'h2);
    chk("w_t1_addr", 32'(cfg_addr_o), 32'h3);
    chk("w_t1_rwn", 32'(cfg_rwn_o), 32'h0);
    chk("w_t1_data", cfg_data_o, 32'hA5);
    chk("w_t1_pready", 32'(PREADY), 32'h0);
    nx; smp;
    chk("w_t2_pready", 32'(PREADY), 32'h1);
    chk("w_t2_pslverr", 32'(PSLVERR), 32'h0);
    chk("w_t2_prdata", PRDATA, 32'h0);
    chk("w_t2_valid", 32'(cfg_valid_o), 32'h0);
    idle; smp;
    chk("w_end_pready", 32'(PREADY), 32'h0);

    // read per 0 reg 0x0B
    setup(12'h02C, 32'h0, 1'b0);
    cfg_data_i[0] = 32'h3;
    cfg_ready_i   = 4'b0001;
    nx; PENABLE = 1'b1; smp;
    chk("r_t1_valid", 32'(cfg_valid_o), 32'h1);
    chk("r_t1_rwn", 32'(cfg_rwn_o), 32'h1);
    chk("r_t1_addr", 32'(cfg_addr_o), 32'hB);
    nx; smp;
    chk("r_t2_valid", 32'(cfg_valid_o), 32'h0);
    chk("r_t2_pready", 32'(PREADY), 32'h1);
    chk("r_t2_prdata", PRDATA, 32'h3);
    chk("r_t2_pslverr", 32'(PSLVERR), 32'h0);
    idle;

    // read per 2, ready low 3 cycles
    setup(12'h114, 32'h0, 1'b0);
    cfg_data_i[2] = 32'hDEAD0000;
    for (int c = 1; c <= 4; c++) begin
      nx;
      PENABLE = 1'b1;
      if (c == 4) begin
        cfg_ready_i   = 4'b0100;
        cfg_data_i[2] = 32'h12345678;
      end
      smp;
      chk($sformatf("ws_c%0d_valid", c), 32'(cfg_valid_o), 32'h4);
      chk($sformatf("ws_c%0d_pready", c), 32'(PREADY), 32'h0);
    end
    nx; smp;
    chk("ws_t5_pready", 32'(PREADY), 32'h1);
    chk("ws_t5_prdata", PRDATA, 32'h12345678);
    chk("ws_t5_valid", 32'(cfg_valid_o), 32'h0);
    idle;

    // bad peripheral index 5
    setup(12'h280, 32'h0, 1'b0);
    smp;
    chk("bad_t0_valid", 32'(cfg_valid_o), 32'h0);
    nx; PENABLE = 1'b1; smp;
    chk("bad_t1_valid", 32'(cfg_valid_o), 32'h0);
    chk("bad_t1_pready", 32'(PREADY), 32'h1);
    chk("bad_t1_pslverr", 32'(PSLVERR), 32'h1);
    chk("bad_t1_prdata", PRDATA, 32'h0);
    idle; smp;
    chk("bad_end_pready", 32'(PREADY), 32'h0);

    // timeout on per 3, then back-to-back read of per 1
    setup(12'h180, 32'h0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      nx;
      PENABLE = 1'b1;
      smp;
      chk($sformatf("to_c%0d_valid", c), 32'(cfg_valid_o), 32'h8);
    end
    nx; smp;
    chk("to_valid", 32'(cfg_valid_o), 32'h0);
    chk("to_pready", 32'(PREADY), 32'h1);
    chk("to_pslverr", 32'(PSLVERR), 32'h1);
    chk("to_prdata", PRDATA, 32'h0);
    setup(12'h080, 32'h0, 1'b0);
    cfg_ready_i   = 4'b0010;
    cfg_data_i[1] = 32'h77;
    smp;
    chk("b2b_t0_pready", 32'(PREADY), 32'h0);
    nx; PENABLE = 1'b1; smp;
    chk("b2b_t1_valid", 32'(cfg_valid_o), 32'h2);
    nx; smp;
    chk("b2b_t2_pready", 32'(PREADY), 32'h1);
    chk("b2b_t2_pslverr", 32'(PSLVERR), 32'h0);
    chk("b2b_t2_prdata", PRDATA, 32'h77);
    idle;

    // PSEL dropped while the cfg access is pending
    setup(12'h080, 32'h0, 1'b0);
    nx; PENABLE = 1'b1; smp;
    chk("drop_t1_valid", 32'(cfg_valid_o), 32'h2);
    nx;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    cfg_ready_i = 4'b0010;
    smp;
    chk("drop_t2_valid", 32'(cfg_valid_o), 32'h2);
    nx; smp;
    chk("drop_t3_valid", 32'(cfg_valid_o), 32'h0);
    chk("drop_t3_pready", 32'(PREADY), 32'h0);
    idle;

    // reset in the middle of a request
    setup(12'h100, 32'hCAFE, 1'b1);
    nx; PENABLE = 1'b1; smp;
    chk("rq_valid", 32'(cfg_valid_o), 32'h4);
    #1 rstn_i = 1'b0;
    #1;
    chk("rq_rst_valid", 32'(cfg_valid_o), 32'h0);
    chk("rq_rst_pready", 32'(PREADY), 32'h0);
    chk("rq_rst_data", cfg_data_o, 32'h0);
    idle;
    nx; rstn_i = 1'b1;
    setup(12'h004, 32'h1234, 1'b1);
    cfg_ready_i = 4'b0001;
    nx; PENABLE = 1'b1; smp;
    chk("post_valid", 32'(cfg_valid_o), 32'h1);
    chk("post_addr", 32'(cfg_addr_o), 32'h1);
    chk("post_data", cfg_data_o, 32'h1234);
    nx; smp;
    chk("post_pready", 32'(PREADY), 32'h1);
    chk("post_pslverr", 32'(PSLVERR), 32'h0);
    idle;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
